// File: rtl/wb_x_arbiter_pkg.sv
// ============================================================================
//  Module      : wb_x_arbiter_pkg
//  Description : Shared widths, payload struct and helpers for the scalar
//                write-back arbiter. The width macros normally come from the
//                shared define set; fallback values are provided here so the
//                slice builds stand-alone.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif

package wb_x_arbiter_pkg;

  localparam int WB_WARP_W = `DEPTH_WARP;
  localparam int WB_REG_W  = `REGIDX_WIDTH + `REGEXT_WIDTH;
  localparam int WB_DATA_W = `XLEN;

  // One write-back beat as held in the output register.
  typedef struct packed {
    logic [WB_WARP_W-1:0] warp_id;
    logic                 wxd;
    logic [WB_REG_W-1:0]  reg_idxw;
    logic [WB_DATA_W-1:0] data;
  } wb_payload_t;

  // Index increment with wrap-around at n (round-robin pointer advance).
  function automatic int wb_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
//  Module      : wb_rr_arbiter
//  Description : NUM_SRC-wide single-grant arbiter. With WB_X_RR_ARB_EN
//                defined it is round-robin (pointer register inside, search
//                from the pointer upward with wrap). Without the macro it is
//                fixed priority, lowest index wins, with no state at all.
//                NUM_SRC must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arbiter
  import wb_x_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
`ifdef WB_X_RR_ARB_EN
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_advance,
`endif
  input  logic [NUM_SRC-1:0] i_req,
  output logic [NUM_SRC-1:0] o_grant
);

  logic w_found;

`ifdef WB_X_RR_ARB_EN
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;

  // Rotating search: first requester at or above the pointer, wrapping.
  always_comb begin : c_rr_search
    int j;
    j       = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    o_grant = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = (int'(r_ptr) + k) % NUM_SRC;
      if (!w_found && i_req[j]) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        w_gidx     = PW'(j);
      end
    end
  end

  // Pointer moves past the winner only when a transfer actually happens.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= PW'(wb_wrap_inc(int'(w_gidx), NUM_SRC));
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin : c_fixed_search
    w_found = 1'b0;
    o_grant = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_found && i_req[k]) begin
        w_found    = 1'b1;
        o_grant[k] = 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/wb_x_arbiter.sv
// ============================================================================
//  Module      : wb_x_arbiter
//  Description : Arbitrates NUM_SRC scalar write-back sources onto the single
//                scalar register-file write port through one output register
//                stage (bubble-free: reload whenever empty or draining).
//                Config macro: WB_X_RR_ARB_EN selects round-robin
//                arbitration; undefined gives fixed lowest-index priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_x_arbiter
  import wb_x_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [NUM_SRC-1:0]                              in_valid_i,
  output logic [NUM_SRC-1:0]                              in_ready_o,
  input  logic [NUM_SRC*`DEPTH_WARP-1:0]                  in_warp_id_i,
  input  logic [NUM_SRC-1:0]                              in_wxd_i,
  input  logic [NUM_SRC*(`REGIDX_WIDTH+`REGEXT_WIDTH)-1:0] in_reg_idxw_i,
  input  logic [NUM_SRC*`XLEN-1:0]                        in_wb_wxd_rd_i,
  output logic                                            out_valid_o,
  input  logic                                            out_ready_i,
  output logic [`DEPTH_WARP-1:0]                          out_warp_id_o,
  output logic                                            out_wxd_o,
  output logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0]          out_reg_idxw_o,
  output logic [`XLEN-1:0]                                out_wb_wxd_rd_o,
  output logic [NUM_SRC-1:0]                              out_src_o
);

  logic               w_load_en;
  logic [NUM_SRC-1:0] w_grant;
  wb_payload_t        w_sel;

  logic               r_out_valid;
  logic [NUM_SRC-1:0] r_out_src;
  wb_payload_t        r_out;

  // Output register can take a new beat when empty or being drained now.
  assign w_load_en  = !r_out_valid | out_ready_i;

  // Accept only the granted source, and nobody while reset is asserted.
  assign in_ready_o = rst_n ? (w_grant & {NUM_SRC{w_load_en}}) : '0;

`ifdef WB_X_RR_ARB_EN
  logic w_xfer;
  assign w_xfer = |(in_valid_i & in_ready_o);
`endif

  wb_rr_arbiter #(
    .NUM_SRC   (NUM_SRC)
  ) u_arb (
`ifdef WB_X_RR_ARB_EN
    .clk       (clk),
    .rst_n     (rst_n),
    .i_advance (w_xfer),
`endif
    .i_req     (in_valid_i),
    .o_grant   (w_grant)
  );

  // One-hot AND-OR mux of the granted source's payload.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) begin
        w_sel.warp_id  = in_warp_id_i[i*WB_WARP_W +: WB_WARP_W];
        w_sel.wxd      = in_wxd_i[i];
        w_sel.reg_idxw = in_reg_idxw_i[i*WB_REG_W +: WB_REG_W];
        w_sel.data     = in_wb_wxd_rd_i[i*WB_DATA_W +: WB_DATA_W];
      end
    end
  end

  // Output stage: load on grant, empty on drain with no grant, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      r_out       <= '0;
    end else if (w_load_en) begin
      r_out_valid <= |w_grant;
      if (|w_grant) begin
        r_out     <= w_sel;
        r_out_src <= w_grant;
      end
    end
  end

  assign out_valid_o     = r_out_valid;
  assign out_src_o       = r_out_src;
  assign out_warp_id_o   = r_out.warp_id;
  assign out_wxd_o       = r_out.wxd;
  assign out_reg_idxw_o  = r_out.reg_idxw;
  assign out_wb_wxd_rd_o = r_out.data;

endmodule

`default_nettype wire

// File: tb/tb_wb_x_arbiter.sv
// ============================================================================
//  Module      : tb_wb_x_arbiter
//  Description : Directed self-checking bench for wb_x_arbiter (NUM_SRC=4).
//                Expected grants follow the arbitration mode selected by
//                WB_X_RR_ARB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_x_arbiter;
  import wb_x_arbiter_pkg::*;

  localparam int N = 4;
`ifdef WB_X_RR_ARB_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic                     clk;
  logic                     rst_n;
  logic [N-1:0]             in_valid_i;
  logic [N-1:0]             in_ready_o;
  logic [N*WB_WARP_W-1:0]   in_warp_id_i;
  logic [N-1:0]             in_wxd_i;
  logic [N*WB_REG_W-1:0]    in_reg_idxw_i;
  logic [N*WB_DATA_W-1:0]   in_wb_wxd_rd_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [WB_WARP_W-1:0]     out_warp_id_o;
  logic                     out_wxd_o;
  logic [WB_REG_W-1:0]      out_reg_idxw_o;
  logic [WB_DATA_W-1:0]     out_wb_wxd_rd_o;
  logic [N-1:0]             out_src_o;

  int n_checks = 0;
  int n_errors = 0;

  wb_x_arbiter #(.NUM_SRC(N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_warp_id_i    (in_warp_id_i),
    .in_wxd_i        (in_wxd_i),
    .in_reg_idxw_i   (in_reg_idxw_i),
    .in_wb_wxd_rd_i  (in_wb_wxd_rd_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_warp_id_o   (out_warp_id_o),
    .out_wxd_o       (out_wxd_o),
    .out_reg_idxw_o  (out_reg_idxw_o),
    .out_wb_wxd_rd_o (out_wb_wxd_rd_o),
    .out_src_o       (out_src_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [WB_WARP_W-1:0] w, input logic x,
                         input logic [WB_REG_W-1:0] r, input logic [WB_DATA_W-1:0] d);
    in_warp_id_i[i*WB_WARP_W +: WB_WARP_W]   = w;
    in_wxd_i[i]                              = x;
    in_reg_idxw_i[i*WB_REG_W +: WB_REG_W]    = r;
    in_wb_wxd_rd_i[i*WB_DATA_W +: WB_DATA_W] = d;
  endtask

  initial begin
    int idx;
    logic [N-1:0] exp_g;

    rst_n          = 1'b0;
    out_ready_i    = 1'b1;
    in_valid_i     = 4'b1111;
    in_warp_id_i   = '0;
    in_wxd_i       = '0;
    in_reg_idxw_i  = '0;
    in_wb_wxd_rd_i = '0;

    // Reset state, with every source requesting.
    tick; tick;
    check_eq("rst_in_ready", in_ready_o, 4'b0000);
    check_eq("rst_out_valid", out_valid_o, 1'b0);
    check_eq("rst_out_src", out_src_o, 4'b0000);
    check_eq("rst_out_reg", out_reg_idxw_o, 0);
    check_eq("rst_out_data", out_wb_wxd_rd_o, 0);

    rst_n      = 1'b1;
    in_valid_i = '0;
    for (int i = 0; i < N; i++) set_src(i, WB_WARP_W'(i), 1'b1, WB_REG_W'(10 + i), WB_DATA_W'(32'h1000 + i));
    tick;

    // All sources valid for 8 cycles: one transfer per cycle.
    in_valid_i = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      idx   = RR_MODE ? (c % N) : 0;
      exp_g = N'(1) << idx;
      #1;
      check_eq($sformatf("all_ready_c%0d", c), in_ready_o, exp_g);
      tick;
      check_eq($sformatf("all_src_c%0d", c), out_src_o, exp_g);
      check_eq($sformatf("all_valid_c%0d", c), out_valid_o, 1'b1);
      check_eq($sformatf("all_reg_c%0d", c), out_reg_idxw_o, 10 + idx);
    end
    in_valid_i = '0;
    tick;
    check_eq("drain_valid", out_valid_o, 1'b0);

    // Single source 2.
    set_src(2, 3'd2, 1'b1, 8'd5, 32'hDEADBEEF);
    in_valid_i = 4'b0100;
    #1;
    check_eq("single_ready", in_ready_o, 4'b0100);
    tick;
    check_eq("single_valid", out_valid_o, 1'b1);
    check_eq("single_reg", out_reg_idxw_o, 5);
    check_eq("single_data", out_wb_wxd_rd_o, 32'hDEADBEEF);
    check_eq("single_src", out_src_o, 4'b0100);
    in_valid_i = '0;
    tick;

    // Backpressure: src1 wins, then stalls 3 cycles while src2 waits.
    in_valid_i = 4'b0110;
    #1;
    check_eq("bp_ready0", in_ready_o, 4'b0010);
    tick;
    check_eq("bp_src0", out_src_o, 4'b0010);
    in_valid_i  = 4'b0100;
    out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("bp_stall_ready_c%0d", c), in_ready_o, 4'b0000);
      tick;
      check_eq($sformatf("bp_stall_src_c%0d", c), out_src_o, 4'b0010);
      check_eq($sformatf("bp_stall_reg_c%0d", c), out_reg_idxw_o, 11);
      check_eq($sformatf("bp_stall_valid_c%0d", c), out_valid_o, 1'b1);
    end
    out_ready_i = 1'b1;
    #1;
    check_eq("bp_release_ready", in_ready_o, 4'b0100);
    tick;
    check_eq("bp_second_src", out_src_o, 4'b0100);
    check_eq("bp_second_reg", out_reg_idxw_o, 5);
    in_valid_i = '0;
    tick;
    check_eq("bp_drain_valid", out_valid_o, 1'b0);

    // Reset mid-stream.
    in_valid_i = 4'b1000;
    tick;
    check_eq("mid_pre_valid", out_valid_o, 1'b1);
    check_eq("mid_pre_src", out_src_o, 4'b1000);
    rst_n      = 1'b0;
    in_valid_i = 4'b1010;
    #1;
    check_eq("mid_rst_ready", in_ready_o, 4'b0000);
    tick;
    check_eq("mid_rst_valid", out_valid_o, 1'b0);
    check_eq("mid_rst_src", out_src_o, 4'b0000);
    rst_n = 1'b1;
    #1;
    check_eq("mid_post_ready", in_ready_o, 4'b0010);
    tick;
    check_eq("mid_post_src", out_src_o, 4'b0010);
    in_valid_i = '0;
    tick;

    // No-write request passes through unchanged.
    set_src(0, 3'd5, 1'b0, 8'd7, 32'hCAFEF00D);
    in_valid_i = 4'b0001;
    #1;
    check_eq("nowr_ready", in_ready_o, 4'b0001);
    tick;
    check_eq("nowr_valid", out_valid_o, 1'b1);
    check_eq("nowr_wxd", out_wxd_o, 1'b0);
    check_eq("nowr_reg", out_reg_idxw_o, 7);
    check_eq("nowr_data", out_wb_wxd_rd_o, 32'hCAFEF00D);
    check_eq("nowr_warp", out_warp_id_o, 5);

    // Sources 3 and 1 held valid for 4 cycles.
    in_valid_i = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      exp_g = (RR_MODE && (c % 2 == 1)) ? 4'b1000 : 4'b0010;
      #1;
      check_eq($sformatf("pri_ready_c%0d", c), in_ready_o, exp_g);
      tick;
      check_eq($sformatf("pri_src_c%0d", c), out_src_o, exp_g);
    end
    in_valid_i = '0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_x_arbiter.md
WB_X_ARBITER -- requirements
Module: wb_x_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning the number of scalar write-back sources (ALU, MUL, LSU via its write-back adapter, CSR).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port in_valid_i, input, NUM_SRC, per-source request.
REQ-005 SHALL have port in_ready_o, output, NUM_SRC, per-source accept.
REQ-006 SHALL have port in_warp_id_i, input, NUM_SRC*`DEPTH_WARP, packed warp ids with source i at slice i.
REQ-007 SHALL have port in_wxd_i, input, NUM_SRC, per-source scalar write enable.
REQ-008 SHALL have port in_reg_idxw_i, input, NUM_SRC*(`REGIDX_WIDTH+`REGEXT_WIDTH), packed destination register indices.
REQ-009 SHALL have port in_wb_wxd_rd_i, input, NUM_SRC*`XLEN, packed write data.
REQ-010 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1), the handshake to the scalar register file write port.
REQ-011 SHALL have ports out_warp_id_o, out_wxd_o, out_reg_idxw_o and out_wb_wxd_rd_o, outputs, each one slice wide, carrying the registered winning payload.
REQ-012 SHALL have port out_src_o, output, NUM_SRC, one-hot id of the source held in the output register.

Function
REQ-013 SHALL hold one output register stage; load_en = !out_valid_o | out_ready_i, giving bubble-free back-to-back transfers.
REQ-014 SHALL pick exactly one grant per cycle among sources with in_valid_i high; grant is all-zero when no source is valid.
REQ-015 SHALL drive in_ready_o = grant & {NUM_SRC{load_en}}; a source transfers when in_valid_i[i] & in_ready_o[i].
REQ-016 SHALL, on a transfer, capture the granted payload and set out_src_o = grant, making it visible the next cycle (latency 1 cycle).
REQ-017 SHALL set out_valid_o high the cycle after a transfer; when out_ready_i is high and nothing is granted, out_valid_o goes low.
REQ-018 SHALL hold all outputs stable while out_valid_o & !out_ready_i.
REQ-019 SHALL, on simultaneous drain and fill, replace the register contents in the same cycle.
REQ-020 SHALL accept a request with in_wxd_i low and pass it through unchanged; the consumer ignores that write.
REQ-021 SHALL never assert in_ready_o to an input that is not granted; an ungranted source keeps its request and payload held.

Reset
REQ-022 SHALL, while rst_n is low at a clk edge, clear out_valid_o, out_src_o, all payload registers and the priority pointer to 0.
REQ-023 SHALL drive in_ready_o to all-zero during reset cycles; a transfer pending when reset arrives is dropped.

Configuration
REQ-024 SHALL use macro WB_X_RR_ARB_EN: when defined, arbitration is round-robin.
REQ-025 SHALL, in round-robin mode, search from the pointer upward with wrap-around; on each transfer the pointer becomes (granted index + 1) mod NUM_SRC.
REQ-026 SHALL, in round-robin mode, leave the pointer unchanged in cycles with no transfer.
REQ-027 SHALL, when WB_X_RR_ARB_EN is undefined, use fixed priority where the lowest index wins, with no pointer register.

Structure
REQ-028 SHALL take `DEPTH_WARP, `XLEN, `REGIDX_WIDTH and `REGEXT_WIDTH from the shared define.v; no new widths are introduced.
REQ-029 SHALL place the grant logic in one sub-module, wb_rr_arbiter (NUM_SRC-wide, pointer inside); its fixed-priority form is selected by WB_X_RR_ARB_EN.

Verification (NUM_SRC=4, RR enabled unless stated)
REQ-030 SHALL cover a single source: in_valid_i=4'b0100, payload reg 5 with data 0xDEADBEEF, out_ready_i=1 -> in_ready_o=4'b0100; next cycle out_valid_o=1, out_reg_idxw_o=5, out_wb_wxd_rd_o=0xDEADBEEF, out_src_o=4'b0100.
REQ-031 SHALL cover all sources held valid with out_ready_i=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3, with one transfer per cycle and no bubbles.
REQ-032 SHALL cover backpressure: out_ready_i=0 for 3 cycles with src1 and src2 valid -> outputs frozen on the first winner and in_ready_o=0; after release, the second source appears one cycle later.
REQ-033 SHALL cover fixed priority (macro undefined): sources 3 and 1 held valid for 4 cycles -> source 1 always granted and source 3 starved.
REQ-034 SHALL cover reset mid-stream: rst_n=0 for 1 cycle while out_valid_o=1 -> out_valid_o=0 and in_ready_o=0; the next grant after reset goes to the lowest valid index.
REQ-035 SHALL cover the no-write case: in_wxd_i=0 on src0 -> the request is accepted and out_wxd_o=0 with the payload passed through.
